data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-programmable RV32I load/store memory responder with valid/ready handshakes.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic l_we;
    logic [2:0] l_f3;
    logic [AW+1:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] mem [DEPTH];
    logic a_we;
    logic [2:0] a_f3;
    logic [AW+1:0] a_addr;
    logic [31:0] a_wdata;
    logic enter, illegal, misal, err, unused_addr;
    logic [4:0] sh;
    logic [31:0] word, rd, mask, load;
    // with LATENCY=0 the access happens on the accepting edge, so use the live request there
    assign a_we = state == IDLE ? req_we : l_we;
    assign a_f3 = state == IDLE ? req_func3 : l_f3;
    assign a_addr = state == IDLE ? req_addr[AW+1:0] : l_addr;
    assign a_wdata = state == IDLE ? req_wdata : l_wdata;
    assign unused_addr = ^req_addr[31:AW+2];
    assign req_ready = state == IDLE && rst;
    assign sh = {a_addr[1:0], 3'b000};
    assign word = mem[a_addr[AW+1:2]];
    assign rd = word >> sh;
    assign illegal = a_f3 == 3'd3 || a_f3[2:1] == 2'b11 || (a_f3[2] && a_we);
    assign misal = (a_f3[1:0] == 2'd1 && a_addr[0]) || (a_f3 == 3'd2 && a_addr[1:0] != 2'd0);
    assign err = illegal || misal;
    assign load = a_f3 == 3'd0 ? {{24{rd[7]}}, rd[7:0]} :
                  a_f3 == 3'd4 ? {24'd0, rd[7:0]} :
                  a_f3 == 3'd1 ? {{16{rd[15]}}, rd[15:0]} :
                  a_f3 == 3'd5 ? {16'd0, rd[15:0]} : word;
    assign mask = a_f3[1:0] == 2'd0 ? 32'hFF << sh : a_f3[1:0] == 2'd1 ? 32'hFFFF << sh : '1;
    assign enter = state_nx == RESP && state != RESP;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        if (state == IDLE && req_valid) begin
            cnt_nx = 4'(LATENCY);
            state_nx = LATENCY == 0 ? RESP : WAIT;
        end else if (state == WAIT) begin
            cnt_nx = cnt - 4'd1;
            state_nx = cnt == 4'd1 ? RESP : WAIT;
        end else if (state == RESP && resp_ready) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (enter) begin
                resp_valid <= 1'b1;
                resp_rdata <= (err || a_we) ? 32'd0 : load;
                resp_err <= err;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            l_we <= req_we;
            l_f3 <= req_func3;
            l_addr <= req_addr[AW+1:0];
            l_wdata <= req_wdata;
        end
        if (enter && rst && a_we && !err)
            mem[a_addr[AW+1:2]] <= (word & ~mask) | ((a_wdata << sh) & mask);
    end
endmodule
